// File: rtl/sram_like_responder_if.sv
// Request/response bus of the SRAM-like req/addr_ok/data_ok protocol.
// The initiator drives the request side and the responder answers in order.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_responder.sv
// In-order responder for the SRAM-like protocol in front of a 1-cycle synchronous RAM.
// Define SRAM_RSP_STALL_EN to gate acceptance with a 16-bit stall LFSR.
module sram_like_responder #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] LFSR_SEED = 32'h1
) (
    input  logic                   clk,
    input  logic                   resetn,
    sram_like_responder_if.slave   bus,
    output logic                   mem_en,
    output logic [3:0]             mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(LATENCY);
    localparam logic [TW-1:0] TIMER_INIT = TW'(LATENCY - 1);
    localparam logic [PW:0]   DEPTH_C    = (PW + 1)'(DEPTH);

    if (LATENCY < 2) begin : g_latency_check
        $error("sram_like_responder: LATENCY must be >= 2");
    end
    if ((1 << PW) != DEPTH || DEPTH < 2) begin : g_depth_check
        $error("sram_like_responder: DEPTH must be a power of 2 and >= 2");
    end

    logic              is_wr_q [DEPTH];
    logic [31:0]       data_q  [DEPTH];
    logic [TW-1:0]     timer_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q, cap_ptr_q;
    logic [PW:0]       count_q, fifo_used;
    logic              cap_valid_q, data_ok_q;
    logic [31:0]       rdata_q, head_data;
    logic              stall, accept, head_valid, retire;
    logic              unused_addr;

`ifdef SRAM_RSP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED[15:0];
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // count_q still holds the entry whose data_ok is on the bus, so a full queue never pops through.
    assign accept      = resetn && bus.req && (count_q < DEPTH_C) && !stall;
    assign bus.addr_ok = accept;
    assign mem_en      = accept;
    assign mem_addr    = bus.addr[AW+1:2];
    assign mem_wdata   = bus.wdata;
    assign unused_addr = ^bus.addr[31:AW+2];

    always_comb begin
        mem_we = 4'b0000;
        if (accept && bus.wr) begin
            case (bus.size)
                2'd0:    mem_we = 4'b0001 << bus.addr[1:0];
                2'd1:    mem_we = 4'b0011 << {bus.addr[1], 1'b0};
                default: mem_we = 4'b1111;
            endcase
        end
    end

    assign fifo_used  = count_q - (PW + 1)'(data_ok_q);
    assign head_valid = (fifo_used != '0);
    // Retire when the head timer reaches zero this cycle, so data_ok lands LATENCY after accept.
    assign retire     = head_valid && (timer_q[rd_ptr_q] <= TW'(1));
    // At LATENCY 2 the head may retire in the same cycle its read data arrives.
    assign head_data  = (cap_valid_q && cap_ptr_q == rd_ptr_q) ? mem_rdata : data_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cap_ptr_q   <= '0;
            count_q     <= '0;
            cap_valid_q <= 1'b0;
            data_ok_q   <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            cap_valid_q <= accept && !bus.wr;
            cap_ptr_q   <= wr_ptr_q;
            data_ok_q   <= retire;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (retire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rdata_q  <= is_wr_q[rd_ptr_q] ? 32'h0 : head_data;
            end
            case ({accept, data_ok_q})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (timer_q[i] != '0) begin
                timer_q[i] <= timer_q[i] - 1'b1;
            end
        end
        if (cap_valid_q) begin
            data_q[cap_ptr_q] <= mem_rdata;
        end
        if (accept) begin
            is_wr_q[wr_ptr_q] <= bus.wr;
            data_q[wr_ptr_q]  <= 32'h0;
            timer_q[wr_ptr_q] <= TIMER_INIT;
        end
    end

    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized stream scored against an in-order queue model of the responder.
module tb_sram_like_responder;

    localparam int LAT0 = 2;
    localparam int DEP0 = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_like_responder_if if0 ();
    sram_like_responder_if if1 ();

    logic        m0_en, m1_en;
    logic [3:0]  m0_we, m1_we;
    logic [5:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;

    sram_like_responder #(.AW(6), .DEPTH(DEP0), .LATENCY(LAT0), .LFSR_SEED(32'h1)) dut0 (
        .clk(clk), .resetn(resetn), .bus(if0), .mem_en(m0_en), .mem_we(m0_we),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
    );

    sram_like_responder #(.AW(6), .DEPTH(4), .LATENCY(8), .LFSR_SEED(32'h1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(if1), .mem_en(m1_en), .mem_we(m1_we),
        .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
    );

    // Synchronous RAMs seen by the two responders.
    logic [31:0] ram0 [64];
    logic [31:0] ram1 [64];
    always @(posedge clk) begin
        if (m0_en) begin
            m0_rdata <= ram0[m0_addr];
            for (int b = 0; b < 4; b++) if (m0_we[b]) ram0[m0_addr][8*b +: 8] <= m0_wdata[8*b +: 8];
        end
        if (m1_en) begin
            m1_rdata <= ram1[m1_addr];
            for (int b = 0; b < 4; b++) if (m1_we[b]) ram1[m1_addr][8*b +: 8] <= m1_wdata[8*b +: 8];
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: shadow memory plus a queue of expected responses with due cycles.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q [$];
    logic [31:0] shadow0 [64];
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef SRAM_RSP_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (!resetn) lfsr_m <= 16'h0001;
        else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
`endif

    always @(negedge clk) begin : model
        logic        exp_aok, lane_on;
        logic [3:0]  exp_we;
        logic [31:0] d;
        int          wa;
        exp_aok = resetn && if0.req && (exp_q.size() < DEP0);
`ifdef SRAM_RSP_STALL_EN
        exp_aok = exp_aok && !lfsr_m[0];
`endif
        chk("addr_ok", {31'h0, if0.addr_ok}, {31'h0, exp_aok});
        chk("mem_en", {31'h0, m0_en}, {31'h0, exp_aok});
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            chk("data_ok", {31'h0, if0.data_ok}, 32'h1);
            chk("rdata", if0.rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            chk("data_ok_idle", {31'h0, if0.data_ok}, 32'h0);
        end
        if (exp_aok) begin
            wa = int'(if0.addr[7:2]);
            chk("mem_addr", {26'h0, m0_addr}, wa);
            for (int l = 0; l < 4; l++) begin
                case (if0.size)
                    2'd0:    lane_on = (l == int'(if0.addr[1:0]));
                    2'd1:    lane_on = ((l / 2) == int'(if0.addr[1]));
                    default: lane_on = 1'b1;
                endcase
                exp_we[l] = if0.wr && lane_on;
            end
            chk("mem_we", {28'h0, m0_we}, {28'h0, exp_we});
            if (if0.wr) begin
                for (int l = 0; l < 4; l++) if (exp_we[l]) shadow0[wa][8*l +: 8] = if0.wdata[8*l +: 8];
                d = 32'h0;
            end else begin
                d = shadow0[wa];
            end
            exp_q.push_back('{due: cyc + LAT0, data: d});
        end
        if (!resetn) exp_q.delete();
    end

    typedef struct {
        logic        req, wr;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        logic        aok;
        logic [3:0]  we;
        logic        dok;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic req, wr, input logic [1:0] size,
                                input logic [31:0] addr, wdata, input logic aok,
                                input logic [3:0] we, input logic dok, input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.aok = aok; v.we = we; v.dok = dok; v.rdata = rdata;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, wr, input logic [1:0] size, input logic [31:0] addr, wdata);
        if0.req = req; if0.wr = wr; if0.size = size; if0.addr = addr; if0.wdata = wdata;
    endtask

    vec_t vecs [12];
    logic pend;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram0[i] = i * 32'h01010101;
            ram1[i] = i * 32'h01010101;
            shadow0[i] = i * 32'h01010101;
        end
        ram0[16] = 32'hDEADBEEF;
        shadow0[16] = 32'hDEADBEEF;

        // Reads, byte/half/word writes and read-after-write, one entry per cycle.
        vecs[0]  = mk(1, 0, 2, 32'h40, 0,            1, 4'b0000, 0, 0);
        vecs[1]  = mk(0, 0, 2, 32'h0,  0,            0, 4'b0000, 0, 0);
        vecs[2]  = mk(0, 0, 2, 32'h0,  0,            0, 4'b0000, 1, 32'hDEADBEEF);
        vecs[3]  = mk(1, 1, 0, 32'h43, 32'hAA000000, 1, 4'b1000, 0, 0);
        vecs[4]  = mk(1, 0, 2, 32'h40, 0,            1, 4'b0000, 0, 0);
        vecs[5]  = mk(1, 1, 1, 32'h47, 32'h5A5A0000, 1, 4'b1100, 1, 32'h0);
        vecs[6]  = mk(1, 1, 3, 32'h4B, 32'h12345678, 1, 4'b1111, 1, 32'hAAADBEEF);
        vecs[7]  = mk(1, 0, 2, 32'h44, 0,            1, 4'b0000, 1, 32'h0);
        vecs[8]  = mk(1, 0, 2, 32'h48, 0,            1, 4'b0000, 1, 32'h0);
        vecs[9]  = mk(0, 0, 2, 32'h0,  0,            0, 4'b0000, 1, 32'h5A5A1111);
        vecs[10] = mk(0, 0, 2, 32'h0,  0,            0, 4'b0000, 1, 32'h12345678);
        vecs[11] = mk(0, 0, 2, 32'h0,  0,            0, 4'b0000, 0, 0);

        resetn = 1'b0;
        drive0(1, 0, 2, 32'h40, 0);
        if1.req = 1'b0; if1.wr = 1'b0; if1.size = 2'd2; if1.addr = 32'h40; if1.wdata = 0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_addr_ok", {31'h0, if0.addr_ok}, 32'h0);
        chk("rst_mem_en", {31'h0, m0_en}, 32'h0);
        chk("rst_data_ok", {31'h0, if0.data_ok}, 32'h0);
        chk("rst_rdata", if0.rdata, 32'h0);
        chk("rst_data_ok1", {31'h0, if1.data_ok}, 32'h0);
        next_cycle();
        resetn = 1'b1;
        drive0(0, 0, 2, 0, 0);
        next_cycle();

`ifndef SRAM_RSP_STALL_EN
        for (int i = 0; i < 12; i++) begin
            drive0(vecs[i].req, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("tbl%0d_addr_ok", i), {31'h0, if0.addr_ok}, {31'h0, vecs[i].aok});
            chk($sformatf("tbl%0d_mem_we", i), {28'h0, m0_we}, {28'h0, vecs[i].we});
            chk($sformatf("tbl%0d_data_ok", i), {31'h0, if0.data_ok}, {31'h0, vecs[i].dok});
            if (vecs[i].dok) chk($sformatf("tbl%0d_rdata", i), if0.rdata, vecs[i].rdata);
            next_cycle();
        end

        // 16 back-to-back reads give 16 back-to-back responses across pointer wraps.
        for (int c = 0; c < 20; c++) begin
            drive0(c < 16, 0, 2, 32'(4 * (20 + c)), 0);
            @(negedge clk);
            if (c < 16) chk($sformatf("b2b_addr_ok%0d", c), {31'h0, if0.addr_ok}, 32'h1);
            chk($sformatf("b2b_data_ok%0d", c), {31'h0, if0.data_ok}, {31'h0, c >= 2 && c < 18});
            next_cycle();
        end

        // Reset with three reads in flight: only the response already registered survives.
        for (int c = 0; c < 10; c++) begin
            resetn = (c != 3);
            drive0(c < 3, 0, 2, 32'(4 * c), 0);
            @(negedge clk);
            chk($sformatf("rst_flight_data_ok%0d", c), {31'h0, if0.data_ok}, {31'h0, c == 2 || c == 3});
            next_cycle();
        end
        for (int c = 0; c < 4; c++) begin
            drive0(c == 0, 0, 2, 32'h40, 0);
            @(negedge clk);
            chk($sformatf("post_rst_data_ok%0d", c), {31'h0, if0.data_ok}, {31'h0, c == 2});
            if (c == 2) chk("post_rst_rdata", if0.rdata, 32'hAAADBEEF);
            next_cycle();
        end

        // Full queue on the long-latency instance: refuse while full, even on a retire cycle.
        for (int c = 0; c < 10; c++) begin
            if1.req = 1'b1;
            @(negedge clk);
            chk($sformatf("full_addr_ok%0d", c), {31'h0, if1.addr_ok}, {31'h0, c < 4 || c == 9});
            chk($sformatf("full_data_ok%0d", c), {31'h0, if1.data_ok}, {31'h0, c >= 8});
            if (c == 8) chk("full_rdata", if1.rdata, 32'h10101010);
            next_cycle();
        end
        if1.req = 1'b0;
        repeat (12) next_cycle();
`endif

        // Random stream with occasional resets, holding each request until accepted.
        pend = 1'b0;
        for (int n = 0; n < 800; n++) begin
            resetn = ($urandom_range(0, 199) != 0);
            if (!pend) begin
                drive0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                       {$urandom_range(0, 255), 8'($urandom_range(0, 255))}, $urandom);
            end
            @(negedge clk);
            pend = resetn && if0.req && !if0.addr_ok;
            next_cycle();
        end
        resetn = 1'b1;
        drive0(0, 0, 2, 0, 0);
        repeat (20) next_cycle();
        chk("drain_empty", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
